// File: rtl/gpio_bus_arbiter.sv
// Grants one GPIO sub-port per bus transaction and returns its response on the
// shared path, with select checking, an access timeout and an error counter.
//
// state  | meaning
// IDLE   | waiting for req_i; illegal selects answer with an error directly
// ACCESS | granted port selected, waiting for its ack or for the timer to expire
// RESP   | one-cycle ack_o with registered rdata_o/err_o
module gpio_bus_arbiter #(
    parameter int N_PORTS = 5,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [31:0]          wdata_i,
    input  logic [N_PORTS-1:0]   port_sel_i,
    output logic [N_PORTS-1:0]   port_sel_o,
    output logic                 port_we_o,
    output logic [ADDR_W-1:0]    port_addr_o,
    output logic [31:0]          port_wdata_o,
    input  logic [N_PORTS-1:0]   port_ack_i,
    input  logic [N_PORTS*32-1:0] port_rdata_i,
    output logic                 ack_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic [7:0]           err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Down-counter loaded so that it hits zero on the TIMEOUT-th ACCESS cycle.
    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_PORTS-1:0]   r_sel;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [31:0]          r_wdata;
    logic [15:0]          r_tmr;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic [7:0]           r_err_cnt;

    logic                 w_sel_legal;
    logic                 w_grant_ack;
    logic                 w_tmr_done;
    logic [31:0]          w_grant_rdata;
    logic                 w_load;
    logic                 w_done;
    logic                 w_done_err;

    assign w_sel_legal = $onehot(port_sel_i);
    assign w_grant_ack = |(port_ack_i & r_sel);
    assign w_tmr_done  = (r_tmr == 16'd0);

    // Grant is one-hot, so an OR of the masked slices is the granted slice.
    always_comb begin
        w_grant_rdata = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (r_sel[k]) begin
                w_grant_rdata = w_grant_rdata | port_rdata_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_done_err  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    if (w_sel_legal) begin
                        w_state_nxt = ST_ACCESS;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_done      = 1'b1;
                        w_done_err  = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // A granted ack on the timeout cycle still completes normally.
                if (w_grant_ack) begin
                    w_state_nxt = ST_RESP;
                    w_done      = 1'b1;
                end else if (w_tmr_done) begin
                    w_state_nxt = ST_RESP;
                    w_done      = 1'b1;
                    w_done_err  = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tmr     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_load) begin
                r_sel   <= port_sel_i;
                r_we    <= we_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_tmr   <= TMR_LOAD;
            end else if (r_state == ST_ACCESS) begin
                r_tmr <= r_tmr - 16'd1;
            end
            if (w_done) begin
                r_sel   <= '0;
                r_rdata <= w_done_err ? 32'd0 : w_grant_rdata;
                r_err   <= w_done_err;
                if (w_done_err && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign port_sel_o   = r_sel;
    assign port_we_o    = r_we;
    assign port_addr_o  = r_addr;
    assign port_wdata_o = r_wdata;
    assign ack_o        = (r_state == ST_RESP);
    assign rdata_o      = r_rdata;
    assign err_o        = r_err;
    assign busy_o       = (r_state != ST_IDLE);
    assign err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: directed and randomized transactions checked
// against a latency/response model derived from the transaction rules.
module tb_gpio_bus_arbiter;

    localparam int N_PORTS = 5;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req_i = 1'b0;
    logic                  we_i = 1'b0;
    logic [ADDR_W-1:0]     addr_i = '0;
    logic [31:0]           wdata_i = '0;
    logic [N_PORTS-1:0]    port_sel_i = '0;
    logic [N_PORTS-1:0]    port_sel_o;
    logic                  port_we_o;
    logic [ADDR_W-1:0]     port_addr_o;
    logic [31:0]           port_wdata_o;
    logic [N_PORTS-1:0]    port_ack_i = '0;
    logic [N_PORTS*32-1:0] port_rdata_i = '0;
    logic                  ack_o;
    logic [31:0]           rdata_o;
    logic                  err_o;
    logic                  busy_o;
    logic [7:0]            err_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_err_cnt = 0;

    gpio_bus_arbiter #(
        .N_PORTS(N_PORTS),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .port_sel_i  (port_sel_i),
        .port_sel_o  (port_sel_o),
        .port_we_o   (port_we_o),
        .port_addr_o (port_addr_o),
        .port_wdata_o(port_wdata_o),
        .port_ack_i  (port_ack_i),
        .port_rdata_i(port_rdata_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus transaction started in the current (IDLE) cycle. ack_at is the
    // ACCESS cycle (1 = first) in which the granted port acks, 0 = never;
    // spur are acks from other ports held during the whole access.
    task automatic txn(input logic [N_PORTS-1:0] sel, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input int ack_at, input logic [N_PORTS-1:0] spur);
        bit                 legal;
        int                 exp_cyc;
        logic               exp_e;
        logic [31:0]        exp_rd;
        logic [N_PORTS-1:0] spur_m;
        logic [31:0]        slice [N_PORTS];
        bit                 got;
        int                 gidx;

        legal  = ($countones(sel) == 1);
        spur_m = spur & ~sel;
        gidx   = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            slice[k] = $urandom;
            port_rdata_i[32*k +: 32] = slice[k];
            if (sel[k]) gidx = k;
        end

        if (!legal) begin
            exp_cyc = 1; exp_e = 1'b1; exp_rd = 32'd0;
        end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
            exp_cyc = ack_at + 1; exp_e = 1'b0; exp_rd = slice[gidx];
        end else begin
            exp_cyc = TIMEOUT + 1; exp_e = 1'b1; exp_rd = 32'd0;
        end

        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
        port_sel_i = sel; port_ack_i = '0;
        got = 1'b0;

        for (int c = 1; c <= TIMEOUT + 4 && !got; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                port_sel_i = N_PORTS'($urandom);
                we_i       = 1'($urandom);
                addr_i     = ADDR_W'($urandom);
                wdata_i    = $urandom;
            end
            chk("ack_o_timing", 32'(ack_o), 32'(c == exp_cyc));
            chk("port_sel_o", 32'(port_sel_o), (legal && c < exp_cyc) ? 32'(sel) : 32'd0);
            chk("busy_o_active", 32'(busy_o), 32'd1);
            if (legal && c < exp_cyc) begin
                chk("port_we_o", 32'(port_we_o), 32'(we));
                chk("port_addr_o", 32'(port_addr_o), 32'(addr));
                chk("port_wdata_o", port_wdata_o, wdata);
            end
            if (ack_o) begin
                got = 1'b1;
                chk("rdata_o", rdata_o, exp_rd);
                chk("err_o", 32'(err_o), 32'(exp_e));
                req_i = 1'b0;
                port_ack_i = '0;
            end else begin
                port_ack_i = spur_m | ((c == ack_at) ? sel : '0);
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        req_i = 1'b0;
        port_ack_i = '0;

        if (exp_e && exp_err_cnt < 255) exp_err_cnt++;

        @(posedge clk); #1;
        chk("ack_o_single", 32'(ack_o), 32'd0);
        chk("busy_o_idle", 32'(busy_o), 32'd0);
        chk("rdata_o_hold", rdata_o, exp_rd);
        chk("err_o_hold", 32'(err_o), 32'(exp_e));
        chk("err_cnt_o", 32'(err_cnt_o), 32'(exp_err_cnt));
    endtask

    initial begin
        logic [N_PORTS-1:0] rsel;

        #1;
        chk("rst_port_sel_o", 32'(port_sel_o), 32'd0);
        chk("rst_ack_o", 32'(ack_o), 32'd0);
        chk("rst_busy_o", 32'(busy_o), 32'd0);
        chk("rst_rdata_o", rdata_o, 32'd0);
        chk("rst_err_o", 32'(err_o), 32'd0);
        chk("rst_err_cnt_o", 32'(err_cnt_o), 32'd0);
        chk("rst_port_we_o", 32'(port_we_o), 32'd0);
        chk("rst_port_addr_o", 32'(port_addr_o), 32'd0);
        chk("rst_port_wdata_o", port_wdata_o, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        txn(5'b00100, 1'b0, 8'h10, 32'h0, 1, 5'b00000);
        txn(5'b00001, 1'b1, 8'h04, 32'h0000_00FF, 3, 5'b00000);
        txn(5'b00011, 1'b0, 8'h00, 32'h0, 1, 5'b00000);
        txn(5'b00000, 1'b0, 8'h00, 32'h0, 1, 5'b00000);
        chk("err_cnt_after_illegal", 32'(err_cnt_o), 32'd2);
        txn(5'b01000, 1'b0, 8'h20, 32'h0, 0, 5'b00000);
        txn(5'b10000, 1'b0, 8'h30, 32'h0, TIMEOUT, 5'b00110);
        txn(5'b00010, 1'b1, 8'h7F, 32'hDEAD_BEEF, TIMEOUT + 1, 5'b11101);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) rsel = N_PORTS'(1) << $urandom_range(0, N_PORTS - 1);
            else                           rsel = N_PORTS'($urandom_range(0, 31));
            txn(rsel, 1'($urandom), ADDR_W'($urandom), $urandom,
                int'($urandom_range(0, TIMEOUT + 2)), N_PORTS'($urandom));
        end

        // Reset in the middle of an access: everything clears, no ack
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'h55; wdata_i = 32'h1234_5678;
        port_sel_i = 5'b00100; port_ack_i = '0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy_o", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_port_sel_o", 32'(port_sel_o), 32'd0);
        chk("mid_rst_port_we_o", 32'(port_we_o), 32'd0);
        chk("mid_rst_port_addr_o", 32'(port_addr_o), 32'd0);
        chk("mid_rst_port_wdata_o", port_wdata_o, 32'd0);
        chk("mid_rst_ack_o", 32'(ack_o), 32'd0);
        chk("mid_rst_rdata_o", rdata_o, 32'd0);
        chk("mid_rst_err_o", 32'(err_o), 32'd0);
        chk("mid_rst_busy_o", 32'(busy_o), 32'd0);
        chk("mid_rst_err_cnt_o", 32'(err_cnt_o), 32'd0);
        req_i = 1'b0;
        exp_err_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (TIMEOUT + 3) begin
            @(posedge clk); #1;
            chk("post_rst_no_ack", 32'(ack_o), 32'd0);
        end

        // Saturation of the error counter
        for (int i = 0; i < 260; i++) begin
            txn((i % 2 == 0) ? 5'b11000 : 5'b00000, 1'b0, 8'h00, 32'h0, 0, 5'b00000);
        end
        chk("err_cnt_saturated", 32'(err_cnt_o), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
